// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   op_e        : operation encoding carried on the SUB input (ADD=0, SUB=1)
//   chunk_width : bits resolved per pipeline stage
package addsub_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice.
//   a_i, b_i   : operand chunks (b_i already inverted for subtraction)
//   cin_i      : carry into the chunk
//   sum_o      : chunk sum
//   cout_o     : carry out of the chunk MSB
//   msb_cin_o  : carry into the chunk MSB (used for signed overflow)
module addsub_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             msb_cin_o
);

  logic [CHUNK:0] total;

  assign total     = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
  assign sum_o     = total[CHUNK-1:0];
  assign cout_o    = total[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
  assign msb_cin_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ sum_o[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice resolved per stage.
//   CLK, RST_N           : clock, asynchronous active-low reset
//   IN_VALID/IN_READY    : input handshake (IN_READY = not stalled)
//   A, B, SUB, CIN       : operands, op select, carry/borrow-in
//   OUT_VALID/OUT_READY  : output handshake
//   S, COUT, OVF, ZERO   : registered result and flags
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);

  import addsub_pkg::*;

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  op_e             op;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic             stall;

  // Stage k registers: operands travel whole; chunks <= k of s_q are final.
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] bx_q [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             c_q  [STAGES];
  logic             v_q  [STAGES];
  logic             ovf_q;
  logic             zero_q;

  // Stage k inputs (from the ports for k=0, from stage k-1 otherwise).
  logic [WIDTH-1:0] a_in  [STAGES];
  logic [WIDTH-1:0] bx_in [STAGES];
  logic             c_in  [STAGES];
  logic             v_in  [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];

  logic [CHUNK-1:0] sum_w     [STAGES];
  logic             cout_w    [STAGES];
  logic             msb_cin_w [STAGES];

  assign op       = op_e'(SUB);
  assign bx       = (op == addsub_pkg::SUB) ? ~B : B;
  assign c0       = CIN ^ SUB;
  assign stall    = v_q[STAGES-1] & ~OUT_READY;
  assign IN_READY = ~stall;

  always_comb begin
    v_in[0]  = IN_VALID;
    a_in[0]  = A;
    bx_in[0] = bx;
    c_in[0]  = c0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_in[k]  = v_q[k-1];
      a_in[k]  = a_q[k-1];
      bx_in[k] = bx_q[k-1];
      c_in[k]  = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i       (a_in[k][k*CHUNK +: CHUNK]),
      .b_i       (bx_in[k][k*CHUNK +: CHUNK]),
      .cin_i     (c_in[k]),
      .sum_o     (sum_w[k]),
      .cout_o    (cout_w[k]),
      .msb_cin_o (msb_cin_w[k])
    );
  end

  // Kept apart from the stage-input mux so the adder feedback stays acyclic.
  always_comb begin
    s_d[0]            = '0;
    s_d[0][CHUNK-1:0] = sum_w[0];
    for (int unsigned k = 1; k < STAGES; k++) begin
      s_d[k]                   = s_q[k-1];
      s_d[k][k*CHUNK +: CHUNK] = sum_w[k];
    end
  end

  // Data registers load only behind a valid op, so outputs hold their last
  // result across bubbles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
    end else if (!stall) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k]  <= a_in[k];
          bx_q[k] <= bx_in[k];
          s_q[k]  <= s_d[k];
          c_q[k]  <= cout_w[k];
        end
      end
      if (v_in[STAGES-1]) begin
        ovf_q  <= msb_cin_w[STAGES-1] ^ cout_w[STAGES-1];
        zero_q <= (s_d[STAGES-1] == '0);
      end
    end
  end

  assign OUT_VALID = v_q[STAGES-1];
  assign S         = s_q[STAGES-1];
  assign COUT      = c_q[STAGES-1];
  assign OVF       = ovf_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  logic        CLK = 1'b0;
  logic        RST_N, IN_VALID, IN_READY, SUB, CIN, OUT_VALID, OUT_READY;
  logic        COUT, OVF, ZERO;
  logic [31:0] A, B, S;

  // Parameter-sweep instances
  logic        v8, rdy8, ov8, c8, o8, z8;
  logic [7:0]  a8, s8;
  logic        v64, rdy64, ov64, c64, o64, z64;
  logic [63:0] a64, s64;
  logic        v32, rdy32, ov32, c32, o32, z32;
  logic [31:0] a32, s32;

  int unsigned n_checks = 0, n_pass = 0, cyc_budget = 0;
  logic [33:0] q[$];  // {ovf, cout, s}

  always #5 CLK = ~CLK;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .SUB(SUB), .CIN(CIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .S(S), .COUT(COUT), .OVF(OVF), .ZERO(ZERO));

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut_w8 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(v8), .IN_READY(rdy8),
    .A(a8), .B(8'd1), .SUB(1'b0), .CIN(1'b0), .OUT_VALID(ov8), .OUT_READY(1'b1),
    .S(s8), .COUT(c8), .OVF(o8), .ZERO(z8));

  pipelined_addsub #(.WIDTH(64), .STAGES(8)) dut_w64 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(v64), .IN_READY(rdy64),
    .A(a64), .B(64'd1), .SUB(1'b0), .CIN(1'b0), .OUT_VALID(ov64), .OUT_READY(1'b1),
    .S(s64), .COUT(c64), .OVF(o64), .ZERO(z64));

  pipelined_addsub #(.WIDTH(32), .STAGES(32)) dut_s32 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(v32), .IN_READY(rdy32),
    .A(a32), .B(32'd1), .SUB(1'b0), .CIN(1'b0), .OUT_VALID(ov32), .OUT_READY(1'b1),
    .S(s32), .COUT(c32), .OVF(o32), .ZERO(z32));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sb, input logic ci);
    logic [31:0] bxm;
    logic [32:0] r;
    logic        cm;
    bxm = sb ? ~b : b;
    r   = {1'b0, a} + {1'b0, bxm} + {32'd0, ci ^ sb};
    cm  = a[31] ^ bxm[31] ^ r[31];
    return {cm ^ r[32], r[32], r[31:0]};
  endfunction

  // One clock: drive at the falling edge, check 1 ns later, then wait for the next one.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic sb, input logic ci, input logic ordy,
                       input logic [33:0] exp, output logic acc);
    logic [33:0] e;
    cyc_budget++;
    if (cyc_budget > 60000) begin
      $display("FAIL budget: cycles %0d exceeded limit %0d", cyc_budget, 60000);
      $fatal(1);
    end
    IN_VALID = iv; A = a; B = b; SUB = sb; CIN = ci; OUT_READY = ordy;
    #1;
    check("in_ready", IN_READY, !(OUT_VALID && !OUT_READY));
    if (OUT_VALID) begin
      if (q.size() == 0) check("spurious_out_valid", 1, 0);
      else begin
        e = q[0];
        check("S", S, e[31:0]);
        check("COUT", COUT, e[32]);
        check("OVF", OVF, e[33]);
        check("ZERO", ZERO, e[31:0] == 32'd0);
        if (OUT_READY) void'(q.pop_front());
      end
    end
    acc = iv && IN_READY;
    if (acc) q.push_back(exp);
    @(negedge CLK);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sb,
                      input logic ci, input logic [33:0] exp);
    logic acc;
    do cycle(1'b1, a, b, sb, ci, 1'b1, exp, acc); while (!acc);
  endtask

  logic        acc;
  int unsigned lat, l8, l64, l32;
  logic [63:0] rs8, rs64, rs32;
  logic        rc8, rc64, rc32;
  logic [31:0] ra, rb;
  logic        rsb, rci;

  initial begin
    RST_N = 1'b0; IN_VALID = 0; A = '0; B = '0; SUB = 0; CIN = 0; OUT_READY = 1;
    v8 = 0; a8 = '0; v64 = 0; a64 = '0; v32 = 0; a32 = '0;
    repeat (3) @(negedge CLK);
    check("rst_out_valid", OUT_VALID, 0);
    check("rst_S", S, 0);
    check("rst_COUT", COUT, 0);
    check("rst_OVF", OVF, 0);
    check("rst_ZERO", ZERO, 1);
    check("rst_in_ready", IN_READY, 1);
    RST_N = 1'b1;
    @(negedge CLK);

    // Mid-stream async reset drops everything in flight.
    for (int i = 0; i < 6; i++) send(32'(i), 32'd3, 1'b0, 1'b0, model(32'(i), 32'd3, 1'b0, 1'b0));
    IN_VALID = 0;
    check("pre_rst_out_valid", OUT_VALID, 1);
    #3 RST_N = 1'b0;
    #1 check("async_rst_out_valid", OUT_VALID, 0);
    check("async_rst_ZERO", ZERO, 1);
    q.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);

    // Latency: accept edge counts as the first of four.
    IN_VALID = 1; A = 32'h0000_00FF; B = 32'd1; SUB = 0; CIN = 0; OUT_READY = 1;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(negedge CLK);
      if (n == 1) IN_VALID = 0;
      if (OUT_VALID) lat = n;
    end
    check("latency", lat, 4);
    check("lat_S", S, 32'h0000_0100);
    check("lat_COUT", COUT, 0);
    @(negedge CLK);
    check("bubble_out_valid", OUT_VALID, 0);
    check("bubble_S_hold", S, 32'h0000_0100);

    // Directed vectors: {ovf, cout, s}
    send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    send(32'd5,         32'd7, 1'b1, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFE});
    send(32'd7,         32'd5, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0000_0002});
    send(32'd7,         32'd5, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});
    send(32'h8000_0000, 32'd1, 1'b1, 1'b0, {1'b1, 1'b1, 32'h7FFF_FFFF});
    send(32'h0000_FFFF, 32'd0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0001_0000});

    // Back-to-back streaming, add then subtract.
    for (int sb = 0; sb < 2; sb++)
      for (int i = 0; i < 256; i += 17)
        for (int j = 0; j < 256; j += 17)
          send(32'(i), 32'(j), sb[0], 1'b0, model(32'(i), 32'(j), sb[0], 1'b0));

    // Random valid and backpressure.
    for (int n = 0; n < 400; n++) begin
      ra = $urandom; rb = $urandom; rsb = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 1)), ra, rb, rsb, rci, 1'($urandom_range(0, 1)),
            model(ra, rb, rsb, rci), acc);
    end
    for (int n = 0; n < 40 && q.size() > 0; n++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, acc);
    check("drain", q.size(), 0);
    IN_VALID = 0;

    // Parameter sweep: full carry ripple across every chunk.
    check("w8_rdy", rdy8, 1);
    check("w64_rdy", rdy64, 1);
    check("s32_rdy", rdy32, 1);
    v8 = 1; a8 = 8'hFF; v64 = 1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; v32 = 1; a32 = 32'hFFFF_FFFF;
    l8 = 0; l64 = 0; l32 = 0; rs8 = '1; rs64 = '1; rs32 = '1; rc8 = 0; rc64 = 0; rc32 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (n == 1) begin v8 = 0; v64 = 0; v32 = 0; end
      if (ov8  && l8  == 0) begin l8  = n; rs8  = 64'(s8);  rc8  = c8;  end
      if (ov64 && l64 == 0) begin l64 = n; rs64 = s64;      rc64 = c64; end
      if (ov32 && l32 == 0) begin l32 = n; rs32 = 64'(s32); rc32 = c32; end
    end
    check("w8_latency", l8, 1);
    check("w8_S", rs8, 0);
    check("w8_COUT", rc8, 1);
    check("w64_latency", l64, 8);
    check("w64_S", rs64, 0);
    check("w64_COUT", rc64, 1);
    check("s32_latency", l32, 32);
    check("s32_S", rs32, 0);
    check("s32_COUT", rc32, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
